prog_loader: RTL and testbench

- Synthesizable boot sequencer that sits between a byte-stream source (UART receiver or bench driver) and the CPU's unified instruction/data memory.
- Holds the CPU in reset, zero-fills the memory, then loads a program word by word from the stream.
- Releases the CPU for a programmable cycle budget, then freezes it for inspection.
- Generalises the fixed clear/load/run-for-N bring-up flow to parametrised memory width and depth, with a streamed source and error reporting.

---
 rtl/prog_loader.sv | 178 +++++++++++++++++
 tb/tb_prog_loader.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Boot sequencer: holds the CPU in reset, zero-fills memory, loads a big-endian byte stream,
// then runs the CPU for a cycle budget. Define PROG_LOADER_CHECKSUM_EN for a trailing checksum word.
module prog_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  external_clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic                  rx_last,
  output logic                  rx_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [31:0]           run_limit,
  output logic                  cpu_rst,
  output logic                  cpu_ena,
  output logic [ADDR_WIDTH:0]   words_loaded,
  output logic                  done,
  output logic                  error
);
  localparam int NB  = DATA_WIDTH / 8;
  localparam int BCW = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  logic [2:0]            state;
  logic [BCW-1:0]        byte_cnt;
  logic [DATA_WIDTH-1:0] asm_q, shifted, word_next;
  logic                  word_full, room, fin;
  logic [31:0]           run_cnt, limit_q;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q;
`endif

  // A short final word is left-justified so the missing low bytes read as zero.
  always_comb begin
    shifted   = (asm_q << 8) | DATA_WIDTH'(rx_data);
    word_full = (int'(byte_cnt) == NB - 1);
    word_next = shifted << (8 * (NB - 1 - int'(byte_cnt)));
    room      = ~words_loaded[ADDR_WIDTH];
  end

  always_ff @(posedge external_clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      rx_ready     <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      cpu_rst      <= 1'b1;
      cpu_ena      <= 1'b0;
      words_loaded <= '0;
      done         <= 1'b0;
      error        <= 1'b0;
      byte_cnt     <= '0;
      asm_q        <= '0;
      fin          <= 1'b0;
      run_cnt      <= '0;
      limit_q      <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q        <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            state        <= S_CLEAR;
            mem_we       <= 1'b1;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            cpu_rst      <= 1'b1;
            cpu_ena      <= 1'b0;
            words_loaded <= '0;
            done         <= 1'b0;
            error        <= 1'b0;
            byte_cnt     <= '0;
            fin          <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q        <= '0;
`endif
          end
        end
        S_CLEAR: begin
          if (&mem_addr) begin
            state    <= S_LOAD;
            rx_ready <= 1'b1;
          end else begin
            mem_we   <= 1'b1;
            mem_addr <= mem_addr + ADDR_WIDTH'(1);
          end
        end
        S_LOAD: begin
          if (fin) begin
            fin      <= 1'b0;
            state    <= S_RUN;
            cpu_rst  <= 1'b0;
            cpu_ena  <= 1'b1;
            run_cnt  <= '0;
            limit_q  <= run_limit;
          end else if (rx_valid && rx_ready) begin
            asm_q <= shifted;
            if (!(word_full || rx_last)) begin
              byte_cnt <= byte_cnt + BCW'(1);
            end else begin
              byte_cnt <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
              // The rx_last word is the trailer: compared, never written.
              if (rx_last) begin
                rx_ready <= 1'b0;
                if (word_full && word_next == sum_q) begin
                  state   <= S_RUN;
                  cpu_rst <= 1'b0;
                  cpu_ena <= 1'b1;
                  run_cnt <= '0;
                  limit_q <= run_limit;
                end else begin
                  error   <= 1'b1;
                  done    <= 1'b1;
                  cpu_rst <= 1'b0;
                  state   <= S_HALT;
                end
              end else if (room) begin
                mem_we       <= 1'b1;
                mem_addr     <= words_loaded[ADDR_WIDTH-1:0];
                mem_wdata    <= word_next;
                words_loaded <= words_loaded + (ADDR_WIDTH+1)'(1);
                sum_q        <= sum_q + word_next;
              end else begin
                error <= 1'b1;
              end
`else
              if (room) begin
                mem_we       <= 1'b1;
                mem_addr     <= words_loaded[ADDR_WIDTH-1:0];
                mem_wdata    <= word_next;
                words_loaded <= words_loaded + (ADDR_WIDTH+1)'(1);
              end else begin
                error <= 1'b1;
              end
              if (rx_last) begin
                rx_ready <= 1'b0;
                if (!word_full) error <= 1'b1;
                // With a write pending, RUN waits one cycle for it to land.
                if (room) begin
                  fin <= 1'b1;
                end else begin
                  state   <= S_RUN;
                  cpu_rst <= 1'b0;
                  cpu_ena <= 1'b1;
                  run_cnt <= '0;
                  limit_q <= run_limit;
                end
              end
`endif
            end
          end
        end
        S_RUN: begin
          run_cnt <= run_cnt + 32'd1;
          if (limit_q != 32'd0 && run_cnt + 32'd1 == limit_q) begin
            state   <= S_HALT;
            cpu_ena <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// Directed + randomized bench for prog_loader (DATA_WIDTH=32, ADDR_WIDTH=4) against a stream-level model.
module tb_prog_loader;
  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int NB    = DW / 8;
  localparam int DEPTH = 1 << AW;

  logic          clk, rst, start, rx_valid, rx_last;
  logic [7:0]    rx_data;
  logic          rx_ready, mem_we, cpu_rst, cpu_ena, done, error;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [31:0]   run_limit;
  logic [AW:0]   words_loaded;

  prog_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .external_clk(clk), .rst(rst), .start(start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_last(rx_last), .rx_ready(rx_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .run_limit(run_limit), .cpu_rst(cpu_rst), .cpu_ena(cpu_ena),
    .words_loaded(words_loaded), .done(done), .error(error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int            checks = 0;
  int            errors = 0;
  int            ena_cnt = 0;
  int            nwr = 0;
  logic [DW-1:0] shadow  [DEPTH];
  logic [DW-1:0] exp_mem [DEPTH];
  logic [7:0]    sb [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every cycle passes through here: sample on the falling edge and mirror memory writes.
  task automatic tick();
    @(negedge clk);
    if (mem_we === 1'b1) begin
      shadow[mem_addr] = mem_wdata;
      nwr++;
    end
    if (cpu_ena === 1'b1) ena_cnt++;
  endtask

  task automatic fill_rand(input int n);
    sb.delete();
    repeat (n) sb.push_back(8'($urandom));
  endtask

  task automatic do_clear();
    int  n, t;
    bit  seq_ok;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("clr_done_low", done, 0);
    check("clr_wl_zero", words_loaded, 0);
    check("clr_err_zero", error, 0);
    n = 0; t = 0; seq_ok = 1'b1;
    while (rx_ready !== 1'b1 && t < 100) begin
      if (mem_we === 1'b1) begin
        if (mem_addr !== AW'(n) || mem_wdata !== '0) seq_ok = 1'b0;
        n++;
      end
      tick();
      t++;
    end
    check("clr_writes", n, DEPTH);
    check("clr_seq", seq_ok, 1);
    check("clr_rx_ready", rx_ready, 1);
    check("clr_cpu_rst", cpu_rst, 1);
  endtask

  task automatic send_stream(input bit gaps, input bit use_last);
    bit acc;
    int t;
    for (int i = 0; i < sb.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        rx_valid = 1'b0;
        tick();
      end
      rx_data  = sb[i];
      rx_last  = use_last && (i == sb.size() - 1);
      rx_valid = 1'b1;
      t = 0;
      do begin
        acc = rx_ready;
        tick();
        t++;
      end while (!acc && t < 20);
      if (!acc) check("rx_timeout", acc, 1);
    end
    rx_valid = 1'b0;
    rx_last  = 1'b0;
  endtask

  task automatic run_round(input logic [31:0] lim, input bit gaps);
    int            n, nw, ewl, t;
    bit            eerr, ewrite;
    logic [DW-1:0] w;
    for (int i = 0; i < DEPTH; i++) shadow[i] = $urandom;
    run_limit = lim;
    do_clear();
    // Model: big-endian words, short tail zero-padded, only the first DEPTH words land in memory.
    n      = sb.size();
    nw     = (n + NB - 1) / NB;
    ewl    = (nw > DEPTH) ? DEPTH : nw;
    eerr   = (n % NB != 0) || (nw > DEPTH);
    ewrite = (nw <= DEPTH);
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
    for (int wi = 0; wi < ewl; wi++) begin
      w = '0;
      for (int b = 0; b < NB; b++)
        w = (w << 8) | DW'((wi * NB + b < n) ? sb[wi * NB + b] : 8'h00);
      exp_mem[wi] = w;
    end
    ena_cnt = 0;
    send_stream(gaps, 1'b1);
    check("final_we", mem_we, ewrite);
    check("ready_after_last", rx_ready, 0);
    if (ewrite) begin
      check("cpu_rst_during_wr", cpu_rst, 1);
      tick();
    end
    check("run_cpu_rst", cpu_rst, 0);
    check("run_cpu_ena", cpu_ena, 1);
    check("words_loaded", words_loaded, ewl);
    check("error", error, eerr);
    for (int i = 0; i < DEPTH; i++) check($sformatf("mem[%0d]", i), shadow[i], exp_mem[i]);
    if (lim != 0) begin
      t = 0;
      while (done !== 1'b1 && t < int'(lim) + 20) begin
        tick();
        t++;
      end
      check("halt_done", done, 1);
      check("ena_cycles", ena_cnt, lim);
      check("halt_ena", cpu_ena, 0);
      check("halt_cpu_rst", cpu_rst, 0);
    end
  endtask

  initial begin
    logic [63:0] fixed_bytes;
    int          wr0;
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_last = 1'b0; rx_data = '0; run_limit = '0;
    repeat (3) tick();
    check("rst_cpu_rst", cpu_rst, 1);
    check("rst_cpu_ena", cpu_ena, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_rx_ready", rx_ready, 0);
    check("rst_wl", words_loaded, 0);
    rst = 1'b0;
    tick();

    // Known stream from IDLE, continuous valid, budget 100.
    fixed_bytes = 64'h12345678ABCDEF01;
    sb.delete();
    for (int i = 0; i < 8; i++) sb.push_back(fixed_bytes[63 - 8 * i -: 8]);
    run_round(32'd100, 1'b0);

    // Each later round restarts from HALT.
    fill_rand(6);              run_round(32'($urandom_range(1, 40)), 1'b1);
    fill_rand(DEPTH * NB);     run_round(32'($urandom_range(1, 40)), 1'b1);
    fill_rand(DEPTH * NB + 4); run_round(32'($urandom_range(1, 40)), 1'b0);
    fill_rand(72);             run_round(32'd1, 1'b1);
    fill_rand(1);              run_round(32'($urandom_range(1, 40)), 1'b0);
    repeat (3) begin
      fill_rand($urandom_range(1, 80));
      run_round(32'($urandom_range(1, 40)), 1'b1);
    end

    // Unlimited budget: never halts, start is ignored while running.
    fill_rand(4);
    run_round(32'd0, 1'b0);
    wr0 = nwr;
    for (int i = 0; i < 10000; i++) begin
      start = (i == 5000);
      tick();
    end
    start = 1'b0;
    check("unlim_done", done, 0);
    check("unlim_ena", cpu_ena, 1);
    check("unlim_no_writes", nwr - wr0, 0);

    // Reset mid-run, then mid-load.
    rst = 1'b1;
    tick();
    check("rst_run_ena", cpu_ena, 0);
    check("rst_run_cpu_rst", cpu_rst, 1);
    rst = 1'b0;
    tick();
    do_clear();
    fill_rand(6);
    send_stream(1'b0, 1'b0);
    check("midload_wl", words_loaded, 1);
    rst = 1'b1;
    tick();
    check("rst_load_ready", rx_ready, 0);
    check("rst_load_wl", words_loaded, 0);
    check("rst_load_cpu_rst", cpu_rst, 1);
    check("rst_load_we", mem_we, 0);
    rst = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
